cache_rd_arbiter: RTL
=====================

Name: cache_rd_arbiter

Overview:
- Shares one AXI read-master port (AR/R channels) between the L1 instruction cache and the L1 data cache refill requests.
- Sits between L1C_inst/L1C_data miss interfaces and the bus-side master port in the CPU wrapper.
- Arbitrates round-robin, issues one AXI INCR burst per grant, steers returned beats to the winning cache, and generates each cache's wait signal.

Parameters:
- BURST_LEN, 4, beats per refill transaction (1..16); ARLEN = BURST_LEN-1.
- ID_I, 4'd0, ARID used for instruction-cache transactions.
- ID_D, 4'd1, ARID used for data-cache transactions.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  I-cache read request; held until done.
- i_addr  in  32  I-cache line base address.
- i_wait  out  1  I-cache stall.
- i_rdata  out  32  beat data to I-cache.
- i_rvalid  out  1  beat valid to I-cache.
- d_req  in  1  D-cache read request; held until done.
- d_addr  in  32  D-cache line base address.
- d_wait  out  1  D-cache stall.
- d_rdata  out  32  beat data to D-cache.
- d_rvalid  out  1  beat valid to D-cache.
- ARID  out  4  transaction ID.
- ARADDR  out  32  latched address.
- ARLEN  out  4  BURST_LEN-1.
- ARSIZE  out  3  3'b010 (word).
- ARBURST  out  2  2'b01 (INCR).
- ARVALID  out  1  address valid.
- ARREADY  in  1  address accepted.
- RID  in  4  returned ID.
- RDATA  in  32  returned data.
- RRESP  in  2  response.
- RLAST  in  1  last beat.
- RVALID  in  1  data valid.
- RREADY  out  1  data ready.
- rd_err  out  1  sticky error flag.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; ARVALID=0; RREADY=0; i_/d_rvalid=0; rdata=0; rd_err=0.
  - last_grant=D, so I-cache wins the first tie.
  - Reset mid-transaction aborts immediately. The outstanding bus beats are not the arbiter's concern after reset.
- State IDLE:
  - If exactly one req is asserted, grant it.
  - If both are asserted, grant the requester opposite last_grant.
  - On grant: latch addr into addr_reg, latch the grant, update last_grant, set beat_cnt=0, go to AR.
  - With no req, stay in IDLE.
  - Minimum latency is 1 cycle from req to ARVALID.
- State AR:
  - ARVALID=1; ARADDR=addr_reg; ARID=ID of grantee. These stay stable until ARREADY.
  - On ARVALID&ARREADY, go to R.
  - A new or dropped req during AR is ignored.
- State R:
  - RREADY=1.
  - Each RVALID cycle: grantee rvalid=1 and rdata=RDATA (combinational pass-through); the other side's rvalid=0 and rdata=0.
  - beat_cnt increments on each beat (wraps to 0 only via state exit).
  - On RVALID&RLAST, go to IDLE. Re-arbitration happens in the next cycle, so at least 1 idle cycle separates transactions.
- Wait generation:
  - x_wait = x_req & ~(grantee==x & state==R & RVALID & RLAST).
  - wait deasserts exactly in the last-beat cycle.
  - The non-granted requester's wait is its req.
- Errors (rd_err set, cleared only by reset):
  - RRESP != 2'b00 on any beat.
  - RID != granted ID.
  - RLAST on beat_cnt != BURST_LEN-1.
  - In every error case the transaction still ends on RLAST.
- Missing RLAST:
  - If beat_cnt reaches BURST_LEN-1 and RLAST=0, set rd_err but remain in R until RLAST.
- Requester drops req mid-transaction: the transaction completes on the bus and beats are still steered. The next arbitration then sees the current reqs.
- RVALID outside R is ignored (RREADY=0).
- ARSIZE and ARBURST are constant.

Test Plan:
- Single request: after reset, i_req=1, i_addr=0x0000_1000, ARREADY after 2 cycles, RDATA 0xA0..0xA3 with RLAST on the 4th beat -> ARADDR=0x1000, ARID=0, ARLEN=3. i_rvalid pulses 4 times with matching data, i_wait falls on the 4th beat, d_rvalid stays 0.
- Tie after reset: i_req=d_req=1 (i_addr=0x100, d_addr=0x200) -> I-cache served first (ARADDR=0x100), then D-cache (ARADDR=0x200, ARID=1), with exactly one idle cycle between. d_wait stays high until the D last beat.
- Round-robin fairness: both reqs held continuously for 4 transactions -> grant order I, D, I, D.
- Backpressure: ARREADY low for 5 cycles -> ARVALID=1 and ARADDR/ARID stable all 5 cycles. RVALID gaps of 3 cycles between beats -> rvalid pulses only on RVALID cycles.
- Error cases: RRESP=2'b10 on beat 2 -> rd_err=1 and the transaction still ends on RLAST. Separately, RLAST on beat 2 of 4 -> rd_err=1, return to IDLE.
- Reset mid-burst: assert rst=0 during beat 2 of a D-cache transaction -> same cycle ARVALID=0, RREADY=0, d_rvalid=0, rd_err=0. After release, a pending i_req is granted first.

Source files
------------

// File: rtl/cache_rd_arbiter.sv
// Round-robin arbiter that shares one AXI read master (AR/R) between the
// I-cache and D-cache refill paths. It issues one INCR burst per grant and sends the returned beats to the cache that won the grant.
module cache_rd_arbiter #(
  parameter int         BURST_LEN = 4,
  parameter logic [3:0] ID_I      = 4'd0,
  parameter logic [3:0] ID_D      = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_wait,
  output logic [31:0] i_rdata,
  output logic        i_rvalid,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  output logic        d_wait,
  output logic [31:0] d_rdata,
  output logic        d_rvalid,
  output logic [3:0]  ARID,
  output logic [31:0] ARADDR,
  output logic [3:0]  ARLEN,
  output logic [2:0]  ARSIZE,
  output logic [1:0]  ARBURST,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [3:0]  RID,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RLAST,
  input  logic        RVALID,
  output logic        RREADY,
  output logic        rd_err
);

  typedef enum logic [1:0] {IDLE, AR, R} state_t;

  localparam logic [4:0] LAST_CNT = 5'(BURST_LEN - 1);

  state_t      state, state_nxt;
  logic        gnt_d;      // current grantee: 1 = D-cache
  logic        last_d;     // previous grantee: 1 = D-cache
  logic        gnt_nxt, grant;
  logic [31:0] addr_reg;
  logic [4:0]  beat_cnt;
  logic [3:0]  gnt_id;
  logic        beat, last_beat, err_now;

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    gnt_nxt   = gnt_d;
    case (state)
      IDLE: if (i_req | d_req) begin
        grant     = 1'b1;
        gnt_nxt   = (i_req & d_req) ? ~last_d : d_req;
        state_nxt = AR;
      end
      AR:      if (ARREADY) state_nxt = R;
      R:       if (RVALID & RLAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign gnt_id    = gnt_d ? ID_D : ID_I;
  assign beat      = (state == R) & RVALID;
  assign last_beat = beat & RLAST;

  // A short burst (early RLAST) or an overlong burst (no RLAST at the
  // expected count) is flagged. The burst still ends only on RLAST.
  assign err_now = beat & ((RRESP != 2'b00) | (RID != gnt_id) |
                           (RLAST & (beat_cnt != LAST_CNT)) |
                           (~RLAST & (beat_cnt == LAST_CNT)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      gnt_d    <= 1'b0;
      last_d   <= 1'b1;
      addr_reg <= '0;
      beat_cnt <= '0;
      rd_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        gnt_d    <= gnt_nxt;
        last_d   <= gnt_nxt;
        addr_reg <= gnt_nxt ? d_addr : i_addr;
        beat_cnt <= '0;
      end else if (beat && beat_cnt != 5'h1f) begin
        beat_cnt <= beat_cnt + 5'd1;
      end
      if (err_now) rd_err <= 1'b1;
    end
  end

  assign ARVALID = (state == AR);
  assign ARADDR  = addr_reg;
  assign ARID    = gnt_id;
  assign ARLEN   = 4'(BURST_LEN - 1);
  assign ARSIZE  = 3'b010;
  assign ARBURST = 2'b01;
  assign RREADY  = (state == R);

  assign i_rvalid = beat & ~gnt_d;
  assign d_rvalid = beat &  gnt_d;
  assign i_rdata  = i_rvalid ? RDATA : '0;
  assign d_rdata  = d_rvalid ? RDATA : '0;

  assign i_wait = i_req & ~(last_beat & ~gnt_d);
  assign d_wait = d_req & ~(last_beat &  gnt_d);

endmodule
